// File: rtl/kgp_boot_pkg.sv
// kgp_boot_pkg: loader state encoding and header/word byte counts shared by boot-stage blocks (CKSUM state exists only with PROG_LOADER_CKSUM_EN)
package kgp_boot_pkg;
  localparam int HDR_BYTES = 2;
  localparam int BYTES_PER_WORD = 4;
  typedef enum logic [2:0] {
    IDLE,
    HDR_HI,
    HDR_LO,
    DATA,
    WRITE,
    DONE,
    ERR
`ifdef PROG_LOADER_CKSUM_EN
    , CKSUM
`endif
  } state_t;
endpackage

// File: rtl/prog_loader_byte_to_word.sv
// byte_to_word: MSB-first 8-to-32 assembler; clk/rst, clr restarts a word, en shifts din in, word is the assembly, word_ready flags the 4th byte of a word
module byte_to_word
  import kgp_boot_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        word_ready
);
  logic [1:0] cnt;
  assign word_ready = en && cnt == 2'(BYTES_PER_WORD - 1);
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt  <= '0;
      word <= '0;
    end else if (en) begin
      cnt  <= cnt + 2'd1;
      word <= {word[23:0], din};
    end
  end
endmodule

// File: rtl/prog_loader.sv
// prog_loader: byte-stream boot loader (16-bit word count + big-endian words) writing instruction memory and holding the core in reset; ports clk/rst, start, rx_valid/rx_data/rx_ready, im_we/im_addr/im_wdata, cpu_rst/done/err; PROG_LOADER_CKSUM_EN adds a trailing XOR checksum byte
module prog_loader
  import kgp_boot_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);
  state_t state, nxt;
  logic [15:0] n;
  logic [15:0] hdr;
  logic [ADDR_W:0] idx;
  logic [ADDR_W:0] idx_nxt;
  logic acc, restart, word_ready;
`ifdef PROG_LOADER_CKSUM_EN
  localparam state_t LAST = CKSUM;
  logic [7:0] cks;
  assign rx_ready = state inside {HDR_HI, HDR_LO, DATA, CKSUM};
  always_ff @(posedge clk) begin
    if (rst || restart) cks <= '0;
    else if (acc && state == DATA) cks <= cks ^ rx_data;
  end
`else
  localparam state_t LAST = DONE;
  assign rx_ready = state inside {HDR_HI, HDR_LO, DATA};
`endif
  assign acc      = rx_valid && rx_ready;
  assign restart  = start && state inside {IDLE, DONE, ERR};
  assign hdr      = {n[15:8], rx_data};
  assign idx_nxt  = idx + 1'b1;
  assign im_we    = state == WRITE;
  assign im_addr  = idx[ADDR_W-1:0];
  assign cpu_rst  = state != DONE;
  assign done     = state == DONE;
  assign err      = state == ERR;
  byte_to_word u_b2w (
    .clk        (clk),
    .rst        (rst),
    .clr        (restart),
    .en         (acc && state == DATA),
    .din        (rx_data),
    .word       (im_wdata),
    .word_ready (word_ready)
  );
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE, ERR: nxt = start ? HDR_HI : state;
      HDR_HI: nxt = acc ? HDR_LO : state;
      HDR_LO: nxt = !acc ? state : (hdr == '0 || 32'(hdr) > MAX_WORDS) ? ERR : DATA;
      DATA: nxt = word_ready ? WRITE : state;
      WRITE: nxt = 32'(idx_nxt) == 32'(n) ? LAST : DATA;
`ifdef PROG_LOADER_CKSUM_EN
      CKSUM: nxt = !acc ? state : rx_data == cks ? DONE : ERR;
`endif
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      n   <= '0;
      idx <= '0;
    end else begin
      if (restart) idx <= '0;
      else if (state == WRITE) idx <= idx_nxt;
      if (acc && state == HDR_HI) n[15:8] <= rx_data;
      if (acc && state == HDR_LO) n[7:0] <= rx_data;
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: scoreboard bench for prog_loader; stimulus queues expected writes/done/err, a monitor pops and compares
module tb_prog_loader;
  import kgp_boot_pkg::*;
  logic clk = 0, rst = 1, start = 0, rx_valid = 0;
  logic [7:0] rx_data = 0;
  logic rx_ready, im_we, cpu_rst, done, err;
  logic [9:0] im_addr;
  logic [31:0] im_wdata;
  int vectors = 0, miscompares = 0, cyc = 0;
  typedef struct {
    int         kind;
    logic [9:0] addr;
    logic [31:0] data;
  } exp_t;
  localparam int K_W = 1, K_D = 2, K_E = 3;
  exp_t q[$];
  logic [31:0] words[$];
  prog_loader #(.ADDR_W(10), .MAX_WORDS(1024)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_rst(cpu_rst), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic push(input int k, input logic [9:0] a, input logic [31:0] d);
    exp_t e;
    e.kind = k;
    e.addr = a;
    e.data = d;
    q.push_back(e);
  endtask
  task automatic pop_cmp(input int k, input logic [9:0] a, input logic [31:0] d);
    exp_t e;
    if (q.size() == 0) begin
      chk("unexpected_event", {22'd0, k[9:0], a, d[21:0]}, 64'd0);
      return;
    end
    e = q.pop_front();
    if (e.kind == K_W) chk("write", {k[21:0], a, d}, {e.kind[21:0], e.addr, e.data});
    else chk("event_kind", 64'(k), 64'(e.kind));
  endtask
  initial begin
    bit pd = 0, pe = 0;
    int last_we = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (im_we) begin
          chk("we_rx_ready", 64'(rx_ready), 64'd0);
          last_we = cyc;
          pop_cmp(K_W, im_addr, im_wdata);
        end
        if (done && !pd) begin
          pop_cmp(K_D, 0, 0);
          chk("done_cpu_rst", 64'(cpu_rst), 64'd0);
`ifndef PROG_LOADER_CKSUM_EN
          chk("done_latency", 64'(cyc - last_we), 64'd1);
`endif
        end
        if (err && !pe) begin
          pop_cmp(K_E, 0, 0);
          chk("err_cpu_rst", 64'(cpu_rst), 64'd1);
        end
      end
      pd = done;
      pe = err;
    end
  end
  task automatic send(input logic [7:0] b, input bit gaps);
    int t = 0;
    if (gaps) while ($urandom_range(0, 1) == 1) begin
      rx_valid = 0;
      @(negedge clk);
    end
    rx_valid = 1;
    rx_data = b;
    while (!rx_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!rx_ready) chk("rx_ready_wait", 64'(rx_ready), 64'd1);
    @(negedge clk);
    rx_valid = 0;
  endtask
  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic wait_end(input string nm);
    int t = 0;
    while (!(done || err) && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk(nm, 64'(done || err), 64'd1);
    @(negedge clk);
    chk({nm, "_queue"}, 64'(q.size()), 64'd0);
  endtask
  task automatic prog(input bit gaps);
    logic [15:0] n;
    logic [7:0] x;
    logic [31:0] w;
    n = 16'(words.size());
    x = 0;
    pulse_start();
    send(n[15:8], gaps);
    send(n[7:0], gaps);
    for (int i = 0; i < words.size(); i++) begin
      w = words[i];
      push(K_W, 10'(i), w);
      for (int j = 3; j >= 0; j--) begin
        send(w[j*8 +: 8], gaps);
        x = x ^ w[j*8 +: 8];
      end
    end
`ifdef PROG_LOADER_CKSUM_EN
    send(x, gaps);
`endif
    push(K_D, 0, 0);
  endtask
  task automatic chk_reset(input string nm);
    chk(nm, {21'd0, cpu_rst, rx_ready, im_we, done, err, im_addr, im_wdata},
        {21'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0});
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(negedge clk);
    chk_reset("reset_state");
    rst = 0;
    @(negedge clk);
    chk("idle_cpu_rst", 64'(cpu_rst), 64'd1);
    words.delete();
    words.push_back(32'h20010005);
    words.push_back(32'hFC000000);
    prog(0);
    wait_end("nominal");
    prog(1);
    wait_end("gaps");
    pulse_start();
    chk("hdr0_start_ready", 64'(rx_ready), 64'd1);
    push(K_E, 0, 0);
    send(8'h00, 0);
    send(8'h00, 0);
    wait_end("hdr_zero");
    chk("hdr_zero_err", {62'd0, err, cpu_rst}, 64'd3);
    pulse_start();
    chk("err_cleared", 64'(err), 64'd0);
    push(K_E, 0, 0);
    send(8'h04, 0);
    send(8'h01, 0);
    wait_end("hdr_big");
    pulse_start();
    push(K_W, 0, 32'hA1B2C3D4);
    send(8'h00, 0);
    send(8'h02, 0);
    send(8'hA1, 0);
    send(8'hB2, 0);
    send(8'hC3, 0);
    send(8'hD4, 0);
    send(8'h55, 0);
    send(8'h66, 0);
    rst = 1;
    @(negedge clk);
    chk_reset("midword_reset");
    rst = 0;
    chk("midword_queue", 64'(q.size()), 64'd0);
    words.delete();
    words.push_back(32'hDEADBEEF);
    prog(0);
    wait_end("after_reset");
    start = 1;
    @(negedge clk);
    start = 0;
    chk("reload_flags", {62'd0, cpu_rst, done}, 64'd2);
    push(K_W, 0, 32'h12345678);
    send(8'h00, 0);
    send(8'h01, 0);
    send(8'h12, 0);
    send(8'h34, 0);
    send(8'h56, 0);
    send(8'h78, 0);
`ifdef PROG_LOADER_CKSUM_EN
    send(8'h08, 0);
`endif
    push(K_D, 0, 0);
    wait_end("reload");
`ifdef PROG_LOADER_CKSUM_EN
    pulse_start();
    push(K_W, 0, 32'h11223344);
    push(K_D, 0, 0);
    send(8'h00, 0);
    send(8'h01, 0);
    send(8'h11, 0);
    send(8'h22, 0);
    send(8'h33, 0);
    send(8'h44, 0);
    send(8'h44, 0);
    wait_end("cksum_good");
    pulse_start();
    push(K_W, 0, 32'h11223344);
    push(K_E, 0, 0);
    send(8'h00, 0);
    send(8'h01, 0);
    send(8'h11, 0);
    send(8'h22, 0);
    send(8'h33, 0);
    send(8'h44, 0);
    send(8'h45, 0);
    wait_end("cksum_bad");
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
